// File: rtl/sipo_deserializer_pkg.sv
// sipo_pkg: shared definitions for the serial-to-parallel receive path.
//   DATA_W_DEF / CNT_W_DEF : default word and bit-counter widths
//   state_t                : receiver FSM encoding (also driven on the debug port)
package sipo_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RECEIVE = 2'b01,
        PARITY  = 2'b10,
        HOLD    = 2'b11
    } state_t;

endpackage

// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial input side plus parallel output handshake of the
// deserializer, bundled so the receiver and its driver share one connection.
//   start, bit_en, serial_in : frame start, bit qualifier, MSB-first serial data
//   data_ready               : downstream accepts data_out
//   data_out, data_valid     : recovered word and its valid flag
//   busy, proto_err, parity_err : status
// Modports: master drives the serial side and ready; slave is the deserializer.
interface sipo_deserializer_if #(
    parameter int DATA_W = sipo_pkg::DATA_W_DEF
);
    logic              start;
    logic              bit_en;
    logic              serial_in;
    logic              data_ready;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic              proto_err;
    logic              parity_err;

    modport master (
        output start, bit_en, serial_in, data_ready,
        input  data_out, data_valid, busy, proto_err, parity_err
    );

    modport slave (
        input  start, bit_en, serial_in, data_ready,
        output data_out, data_valid, busy, proto_err, parity_err
    );
endinterface

// File: rtl/sipo_deserializer_bit_counter.sv
// sipo_bit_counter: clearable, enabled bit counter with a terminal-count flag.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear (wins over en)
//   en           : count one sampled bit
//   tc           : count has reached TERM; the counter saturates there
module sipo_bit_counter #(
    parameter int CNT_W = 8,
    parameter int TERM  = 127
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(TERM));
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: samples an MSB-first serial stream and presents the
// assembled DATA_W-bit word on a valid/ready output.
//   clk, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)  : start/bit_en/serial_in in, data_out/data_valid/data_ready
//                  handshake, busy/proto_err/parity_err status
//   state_dbg    : current FSM state (sipo_pkg::state_t encoding)
// Build option PARITY_CHECK_EN: a trailing even-parity bit follows each word
// and parity_err reports a mismatch; without it parity_err is tied to 0.
//
// Handshake: data_valid rises in the cycle the FSM enters HOLD and stays high,
// with data_out stable, until a cycle where data_ready=1; the word is taken on
// that rising edge and data_valid drops the next cycle. data_ready is ignored
// while data_valid=0.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    sipo_deserializer_if.slave  bus,
    output logic [1:0]          state_dbg
);
    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_q;
    logic              proto_q;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_tc;
`ifdef PARITY_CHECK_EN
    logic              parity_q;
`endif

    assign cnt_clr = (state == IDLE) && bus.start;
    assign cnt_en  = (state == RECEIVE) && bus.bit_en;

    sipo_bit_counter #(
        .CNT_W (CNT_W),
        .TERM  (DATA_W - 1)
    ) u_bit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .tc      (cnt_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            proto_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // A start outside IDLE never disturbs the frame; it only flags.
            if (bus.start && (state != IDLE)) begin
                proto_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RECEIVE;
                        busy_q   <= 1'b1;
                        shreg    <= '0;
`ifdef PARITY_CHECK_EN
                        parity_q <= 1'b0;
`endif
                    end
                end

                RECEIVE: begin
                    if (bus.bit_en) begin
                        shreg <= {shreg[DATA_W-2:0], bus.serial_in};
                        if (cnt_tc) begin
`ifdef PARITY_CHECK_EN
                            state   <= PARITY;
`else
                            // Capture straight from the shift path so the
                            // word is ready in the first HOLD cycle.
                            state   <= HOLD;
                            data_q  <= {shreg[DATA_W-2:0], bus.serial_in};
                            valid_q <= 1'b1;
`endif
                        end
                    end
                end

`ifdef PARITY_CHECK_EN
                PARITY: begin
                    // The parity bit is checked but never shifted into the word.
                    if (bus.bit_en) begin
                        state    <= HOLD;
                        data_q   <= shreg;
                        valid_q  <= 1'b1;
                        parity_q <= ^{shreg, bus.serial_in};
                    end
                end
`endif

                HOLD: begin
                    if (bus.data_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.proto_err  = proto_q;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err = parity_q;
`else
    assign bus.parity_err = 1'b0;
`endif
    assign state_dbg      = state;
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed bench for sipo_deserializer (DATA_W=128).
// Inputs change 1 time unit after the rising edge; the scoreboard samples on
// the falling edge. Build with +define+PARITY_CHECK_EN to cover the parity bit.
module tb_sipo_deserializer;
    import sipo_pkg::*;

    localparam int W = 128;
`ifdef PARITY_CHECK_EN
    localparam int PAR_EXTRA = 1;
`else
    localparam int PAR_EXTRA = 0;
`endif

    localparam logic [W-1:0] WORD_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [W-1:0] WORD_B = 128'h80000000_00000000_00000000_00000001;
    localparam logic [W-1:0] WORD_C = 128'hFFFF0000_A5A5C3C3_0F0F1234_5678F00D;
    localparam logic [W-1:0] ONES   = {W{1'b1}};

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] state_dbg;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end by its time limit");
        $fatal(1, "watchdog");
    end

    sipo_deserializer_if #(.DATA_W(W)) bus ();

    sipo_deserializer #(
        .DATA_W (W),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic         valid_prev = 1'b0;
    int           valid_at = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.data_valid && !valid_prev) valid_at = cyc;
            if (bus.data_valid && bus.data_ready) begin
                if (exp_q.size() == 0) check("sb_unexpected_word", bus.data_out, '0);
                else check("sb_data", bus.data_out, exp_q.pop_front());
            end
            valid_prev = bus.data_valid;
        end else begin
            valid_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    int start_at = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start();
        bus.start = 1'b1;
        tick();
        start_at  = cyc;
        bus.start = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        bus.bit_en    = 1'b1;
        bus.serial_in = b;
        tick();
        bus.bit_en    = 1'b0;
        bus.serial_in = 1'b0;
    endtask

    task automatic drive_gap();
        bus.bit_en    = 1'b0;
        bus.serial_in = 1'($urandom_range(0, 1));
        tick();
        bus.serial_in = 1'b0;
    endtask

    // Sends start, the word MSB first, then (parity build) the parity bit.
    // Returns in the first cycle after the last bit's sampling edge.
    task automatic send_frame(input logic [W-1:0] word, input bit gaps,
                              input logic par_bit, input int start_bit);
        exp_q.push_back(word);
        drive_start();
        for (int i = 0; i < W; i++) begin
            if (gaps && i > 0 && (i % 2) == 0) drive_gap();
            if (i == start_bit) bus.start = 1'b1;
            drive_bit(word[W-1-i]);
            bus.start = 1'b0;
        end
`ifdef PARITY_CHECK_EN
        drive_bit(par_bit);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.start      = 1'b0;
        bus.bit_en     = 1'b0;
        bus.serial_in  = 1'b0;
        bus.data_ready = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_data_out",   bus.data_out, '0);
        check("rst_data_valid", W'(bus.data_valid), '0);
        check("rst_busy",       W'(bus.busy), '0);
        check("rst_proto_err",  W'(bus.proto_err), '0);
        check("rst_parity_err", W'(bus.parity_err), '0);
        check("rst_state",      W'(state_dbg), W'(IDLE));
        reset_n = 1'b1;
        tick();

        // T1: plain frame, ready held high
        bus.data_ready = 1'b1;
        send_frame(WORD_A, 1'b0, ^WORD_A, -1);
        check("t1_valid",  W'(bus.data_valid), 1);
        check("t1_data",   bus.data_out, WORD_A);
        check("t1_busy",   W'(bus.busy), 1);
        tick();
        check("t1_latency", W'(valid_at - start_at + 1), W'(129 + PAR_EXTRA));
        check("t1_pulse_end", W'(bus.data_valid), 0);
        check("t1_data_kept", bus.data_out, WORD_A);
        check("t1_idle",   W'(state_dbg), W'(IDLE));

        // T2: same word, bit_en low every third cycle (63 gaps)
        tick();
        send_frame(WORD_A, 1'b1, ^WORD_A, -1);
        check("t2_data", bus.data_out, WORD_A);
        tick();
        check("t2_latency", W'(valid_at - start_at + 1), W'(192 + PAR_EXTRA));

        // T3: downstream stalls for 10 cycles
        bus.data_ready = 1'b0;
        tick();
        send_frame(WORD_B, 1'b0, ^WORD_B, -1);
        begin
            int v_ok = 0;
            int d_ok = 0;
            for (int k = 0; k < 10; k++) begin
                if (bus.data_valid === 1'b1) v_ok++;
                if (bus.data_out === WORD_B) d_ok++;
                tick();
            end
            check("t3_valid_held", W'(v_ok), 10);
            check("t3_data_held",  W'(d_ok), 10);
        end
        bus.data_ready = 1'b1;
        tick();
        check("t3_released", W'(bus.data_valid), 0);
        check("t3_not_busy", W'(bus.busy), 0);
        check("t3_data_kept", bus.data_out, WORD_B);

        // T4: stray start at bit 40
        check("t4_proto_before", W'(bus.proto_err), 0);
        send_frame(WORD_C, 1'b0, ^WORD_C, 40);
        check("t4_data",  bus.data_out, WORD_C);
        check("t4_proto", W'(bus.proto_err), 1);
        repeat (3) tick();
        check("t4_proto_sticky", W'(bus.proto_err), 1);
        check("t4_idle", W'(state_dbg), W'(IDLE));

        // T5: reset in the middle of a frame, then a frame of all ones
        drive_start();
        for (int i = 0; i < 64; i++) drive_bit(1'($urandom_range(0, 1)));
        reset_n = 1'b0;
        #1;
        check("t5_rst_data",  bus.data_out, '0);
        check("t5_rst_valid", W'(bus.data_valid), 0);
        check("t5_rst_busy",  W'(bus.busy), 0);
        check("t5_rst_proto", W'(bus.proto_err), 0);
        check("t5_rst_state", W'(state_dbg), W'(IDLE));
        tick();
        reset_n = 1'b1;
        tick();
        send_frame(ONES, 1'b0, 1'b0, -1);
        check("t5_ones", bus.data_out, ONES);
        tick();

        // T6: parity bit
`ifdef PARITY_CHECK_EN
        tick();
        send_frame(128'h1, 1'b0, 1'b1, -1);
        check("t6_par_good", W'(bus.parity_err), 0);
        tick();
        tick();
        send_frame(128'h1, 1'b0, 1'b0, -1);
        check("t6_par_bad", W'(bus.parity_err), 1);
        tick();
        check("t6_par_held", W'(bus.parity_err), 1);
        drive_start();
        check("t6_par_cleared", W'(bus.parity_err), 0);
        exp_q.push_back(128'h3);
        for (int i = 0; i < W; i++) drive_bit(i >= W - 2);
        drive_bit(1'b0);
        check("t6_data3", bus.data_out, 128'h3);
        tick();
`else
        tick();
        send_frame(128'h1, 1'b0, 1'b1, -1);
        check("t6_data", bus.data_out, 128'h1);
        check("t6_par_tied", W'(bus.parity_err), 0);
        tick();
        check("t6_latency", W'(valid_at - start_at + 1), 129);
`endif

        // Final report
        repeat (2) tick();
        check("sb_drained", W'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
